regfile_arbiter: RTL and testbench
==================================

Name: regfile_arbiter

Overview:
Sits between the core sequencer and the 8x8 register file and owns that file's single write port and read port A. After reset it walks all eight registers writing zero, because the file has no reset of its own. It then passes core traffic through unchanged. It also grants a debug host read and write access to the file, using core-idle slots and a starvation override that stalls the core.

Parameters:
STARVE_LIMIT, 4, consecutive un-granted debug-valid cycles before the core is forcibly stalled (0 = debug always wins immediately)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
core_src_a  in  3  core read select A
core_src_b  in  3  core read select B
core_dst  in  3  core write select
core_we  in  1  core write enable
core_data  in  8  core write data / RIO input value
core_idle  in  1  1 = core needs no register-file access this cycle
core_stall  out  1  1 = core operation this cycle not performed; core holds
dbg_req_valid  in  1  debug request valid
dbg_req_write  in  1  1 = write, 0 = read
dbg_req_addr  in  3  debug register index
dbg_req_data  in  8  debug write data
dbg_req_ready  out  1  request accepted this cycle
dbg_rsp_valid  out  1  one-cycle pulse, read data valid
dbg_rsp_data  out  8  read data
rf_src_a  out  3  to register file src_a
rf_src_b  out  3  to register file src_b
rf_dst  out  3  to register file dst
rf_we  out  1  to register file write_enable
rf_in  out  8  to register file in
rf_out_a  in  8  from register file out_a
init_done  out  1  high once the clear walk has completed

Behaviour:
- States: CLEAR, RUN. Reset (sync, active-high) forces CLEAR with clr_idx=0, starve_cnt=0, init_done=0, dbg_rsp_valid=0, dbg_rsp_data=0x00.
- While reset is high, the outputs reflect CLEAR with clr_idx=0; a write of 0x00 to r0 is harmless.
- CLEAR: rf_we=1, rf_dst=clr_idx, rf_in=0x00, core_stall=1, dbg_req_ready=0, rf_src_a/b=0.
  - clr_idx increments each cycle; after writing index 7 (8 cycles), go to RUN.
  - init_done=1 from the first RUN cycle onward.
- RUN grant: grant = dbg_req_valid & (core_idle | starve_cnt==STARVE_LIMIT). All grant logic is combinational.
  - dbg_req_ready = grant.
  - core_stall = grant & ~core_idle.
- starve_cnt: increments, saturating at STARVE_LIMIT, on dbg_req_valid & ~grant. Clears on grant or when dbg_req_valid=0.
- RUN, no grant: pure passthrough. rf_src_a/b/dst/we/in = core_src_a/src_b/dst/we/data; core_stall=0.
- RUN, grant, write: rf_we=1, rf_dst=dbg_req_addr, rf_in=dbg_req_data. rf_src_a/b = core values (unused). No response is generated.
- RUN, grant, read: rf_we=0, rf_src_a=dbg_req_addr, rf_in=0x00.
  - Next cycle: dbg_rsp_valid=1, dbg_rsp_data = registered rf_out_a.
  - Reading index 7 therefore returns 0x00; RIO is not debug-visible.
- Responses have no backpressure. Back-to-back grants are legal: a response and a new grant may occur in the same cycle.
- The core never loses a write silently. Whenever its cycle is taken, core_stall=1 for that cycle.
- Reset mid-CLEAR or mid-read restarts CLEAR from index 0, and any pending response is dropped (dbg_rsp_valid=0).
- dbg_req_valid during CLEAR: not granted and starve_cnt stays 0. The request waits until RUN.

Test Plan:
- Release reset -> rf_we=1 for exactly 8 cycles with rf_dst 0..7 and rf_in=0x00; core_stall=1 throughout; init_done rises on cycle 9; r0..r6 read back 0x00.
- RUN, core_idle=1, debug write addr 2 data 0x5A -> ready=1, rf_we=1, rf_dst=2, core_stall=0. Then a debug read of addr 2 -> dbg_rsp_valid pulse next cycle with data 0x5A.
- RUN, core_idle=0 continuously, debug read valid held, STARVE_LIMIT=4 -> not granted for 4 cycles; granted on the 5th with core_stall=1 for that single cycle only; core writes before and after land.
- Debug reads of addr 3 then addr 7 back-to-back, core idle -> two consecutive response pulses with data r3 then 0x00.
- Assert reset during the clear walk at index 4, release -> walk restarts at index 0 and takes the full 8 cycles; no dbg_rsp_valid.
- STARVE_LIMIT=0, core busy, debug valid -> granted the same cycle, with core_stall=1.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Register-file port arbiter: clears the 8x8 file after reset, then passes core
// traffic through and slots debug reads/writes into idle cycles or starved cycles.
module regfile_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] core_src_a,
  input  logic [2:0] core_src_b,
  input  logic [2:0] core_dst,
  input  logic       core_we,
  input  logic [7:0] core_data,
  input  logic       core_idle,
  output logic       core_stall,
  input  logic       dbg_req_valid,
  input  logic       dbg_req_write,
  input  logic [2:0] dbg_req_addr,
  input  logic [7:0] dbg_req_data,
  output logic       dbg_req_ready,
  output logic       dbg_rsp_valid,
  output logic [7:0] dbg_rsp_data,
  output logic [2:0] rf_src_a,
  output logic [2:0] rf_src_b,
  output logic [2:0] rf_dst,
  output logic       rf_we,
  output logic [7:0] rf_in,
  input  logic [7:0] rf_out_a,
  output logic       init_done
);
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]    state;
  logic [2:0]    clr_idx;
  logic [SW-1:0] starve_cnt;
  logic          run, grant, rd_grant;
  logic          rsp_vld_q;
  logic [7:0]    rsp_data_q;

  // Reset is folded in combinationally so a held reset presents CLEAR at index 0.
  assign run      = (state == RUN) & ~reset;
  assign grant    = run & dbg_req_valid & (core_idle | (starve_cnt == LIMIT));
  assign rd_grant = grant & ~dbg_req_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      clr_idx    <= '0;
      starve_cnt <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      rsp_vld_q <= rd_grant;
      if (rd_grant) rsp_data_q <= rf_out_a;
      if (state == CLEAR) begin
        clr_idx    <= clr_idx + 3'd1;
        starve_cnt <= '0;
        if (clr_idx == 3'd7) state <= RUN;
      end else if (dbg_req_valid & ~grant) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  always_comb begin
    rf_src_a   = core_src_a;
    rf_src_b   = core_src_b;
    rf_dst     = core_dst;
    rf_we      = core_we;
    rf_in      = core_data;
    core_stall = 1'b0;
    if (!run) begin
      rf_src_a   = '0;
      rf_src_b   = '0;
      rf_dst     = reset ? 3'd0 : clr_idx;
      rf_we      = 1'b1;
      rf_in      = '0;
      core_stall = 1'b1;
    end else if (grant) begin
      // A granted slot taken from a busy core must stall it so no write is lost.
      core_stall = ~core_idle;
      if (dbg_req_write) begin
        rf_we  = 1'b1;
        rf_dst = dbg_req_addr;
        rf_in  = dbg_req_data;
      end else begin
        rf_we    = 1'b0;
        rf_src_a = dbg_req_addr;
        rf_in    = '0;
      end
    end
  end

  assign dbg_req_ready = grant;
  assign dbg_rsp_valid = rsp_vld_q & ~reset;
  assign dbg_rsp_data  = rsp_data_q;
  assign init_done     = run;
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 8x8 register file
// (index 7 reads back the write-data input).
module tb_regfile_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] core_src_a, core_src_b, core_dst;
  logic       core_we, core_idle;
  logic [7:0] core_data;
  logic       dbg_req_valid, dbg_req_write;
  logic [2:0] dbg_req_addr;
  logic [7:0] dbg_req_data;
  logic       core_stall, dbg_req_ready, dbg_rsp_valid, rf_we, init_done;
  logic [7:0] dbg_rsp_data, rf_in, rf_out_a;
  logic [2:0] rf_src_a, rf_src_b, rf_dst;
  logic       core_stall0, dbg_req_ready0, dbg_rsp_valid0, rf_we0, init_done0;
  logic [7:0] dbg_rsp_data0, rf_in0;
  logic [7:0] rf_out_a0;
  logic [2:0] rf_src_a0, rf_src_b0, rf_dst0;
  logic [7:0] rf_mem [8];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .core_src_a(core_src_a), .core_src_b(core_src_b),
    .core_dst(core_dst), .core_we(core_we), .core_data(core_data), .core_idle(core_idle),
    .core_stall(core_stall), .dbg_req_valid(dbg_req_valid), .dbg_req_write(dbg_req_write),
    .dbg_req_addr(dbg_req_addr), .dbg_req_data(dbg_req_data), .dbg_req_ready(dbg_req_ready),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_data(dbg_rsp_data), .rf_src_a(rf_src_a),
    .rf_src_b(rf_src_b), .rf_dst(rf_dst), .rf_we(rf_we), .rf_in(rf_in),
    .rf_out_a(rf_out_a), .init_done(init_done));

  regfile_arbiter #(.STARVE_LIMIT(0)) dut0 (
    .clk(clk), .reset(reset), .core_src_a(core_src_a), .core_src_b(core_src_b),
    .core_dst(core_dst), .core_we(core_we), .core_data(core_data), .core_idle(core_idle),
    .core_stall(core_stall0), .dbg_req_valid(dbg_req_valid), .dbg_req_write(dbg_req_write),
    .dbg_req_addr(dbg_req_addr), .dbg_req_data(dbg_req_data), .dbg_req_ready(dbg_req_ready0),
    .dbg_rsp_valid(dbg_rsp_valid0), .dbg_rsp_data(dbg_rsp_data0), .rf_src_a(rf_src_a0),
    .rf_src_b(rf_src_b0), .rf_dst(rf_dst0), .rf_we(rf_we0), .rf_in(rf_in0),
    .rf_out_a(rf_out_a0), .init_done(init_done0));

  assign rf_out_a0 = 8'h00;

  // Register file model, pre-filled with junk so the clear walk is observable.
  initial for (int i = 0; i < 8; i++) rf_mem[i] = 8'hEE;
  always @(posedge clk) if (rf_we) rf_mem[rf_dst] <= rf_in;
  assign rf_out_a = (rf_src_a == 3'd7) ? rf_in : rf_mem[rf_src_a];

  typedef struct {
    logic       idle, cwe;
    logic [2:0] cdst, csa, csb;
    logic [7:0] cdata;
    logic       dv, dw;
    logic [2:0] da;
    logic [7:0] dd;
    logic       e_stall, e_rdy, e_we;
    logic [2:0] e_dst, e_sa;
    logic [7:0] e_in;
    logic       e_rsv;
    logic [7:0] e_rsd;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic idle, cwe, input logic [2:0] cdst, csa,
                              input logic [7:0] cdata, input logic dv, dw,
                              input logic [2:0] da, input logic [7:0] dd,
                              input logic es, er, ew, input logic [2:0] edst, esa,
                              input logic [7:0] ein, input logic ersv,
                              input logic [7:0] ersd);
    vec_t v;
    v.idle = idle; v.cwe = cwe; v.cdst = cdst; v.csa = csa; v.csb = 3'd4;
    v.cdata = cdata; v.dv = dv; v.dw = dw; v.da = da; v.dd = dd;
    v.e_stall = es; v.e_rdy = er; v.e_we = ew; v.e_dst = edst; v.e_sa = esa;
    v.e_in = ein; v.e_rsv = ersv; v.e_rsd = ersd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    core_idle = v.idle; core_we = v.cwe; core_dst = v.cdst; core_src_a = v.csa;
    core_src_b = v.csb; core_data = v.cdata; dbg_req_valid = v.dv;
    dbg_req_write = v.dw; dbg_req_addr = v.da; dbg_req_data = v.dd;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int k = 0; k < 7; k++)
      tbl[k] = mk(1,0,6,1,8'h77, 1,0,3'(k),8'h00, 0,1,0,0,3'(k),8'h00, 1,8'h00);
    tbl[7]  = mk(1,0,6,1,8'h77, 1,1,2,8'h5A, 0,1,1,2,1,8'h5A, 0,8'h00);
    tbl[8]  = mk(1,0,6,1,8'h77, 1,0,2,8'h00, 0,1,0,0,2,8'h00, 1,8'h5A);
    tbl[9]  = mk(0,1,3,1,8'hC3, 0,0,0,8'h00, 0,0,1,3,1,8'hC3, 0,8'h00);
    tbl[10] = mk(1,0,6,1,8'h77, 1,0,3,8'h00, 0,1,0,0,3,8'h00, 1,8'hC3);
    tbl[11] = mk(1,0,6,1,8'h77, 1,0,7,8'h00, 0,1,0,0,7,8'h00, 1,8'h00);
    tbl[12] = mk(0,0,6,5,8'h77, 0,0,0,8'h00, 0,0,0,0,5,8'h77, 0,8'h00);
    tbl[13] = mk(0,1,1,1,8'h11, 1,1,4,8'h44, 0,0,1,1,1,8'h11, 0,8'h00);
    tbl[14] = mk(1,0,6,1,8'h77, 1,1,4,8'h44, 0,1,1,4,1,8'h44, 0,8'h00);
    tbl[15] = mk(1,0,6,1,8'h77, 1,0,4,8'h00, 0,1,0,0,4,8'h00, 1,8'h44);
    tbl[16] = mk(1,0,6,1,8'h77, 1,0,1,8'h00, 0,1,0,0,1,8'h00, 1,8'h11);

    reset = 1'b1;
    drive(mk(1,0,0,0,8'h00, 0,0,0,8'h00, 0,0,0,0,0,8'h00, 0,8'h00));
    tick();
    chk("rst_init_done", init_done, 0);
    chk("rst_rsp_valid", dbg_rsp_valid, 0);
    chk("rst_rsp_data", dbg_rsp_data, 8'h00);
    chk("rst_we", rf_we, 1);
    chk("rst_dst", rf_dst, 0);
    chk("rst_stall", core_stall, 1);

    // Clear walk with a debug read pending on an idle core: must not be granted.
    reset = 1'b0;
    core_idle = 1'b1; dbg_req_valid = 1'b1; dbg_req_addr = 3'd3;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("clr_we", rf_we, 1);
      chk("clr_dst", rf_dst, k);
      chk("clr_in", rf_in, 8'h00);
      chk("clr_stall", core_stall, 1);
      chk("clr_ready", dbg_req_ready, 0);
      chk("clr_ready_l0", dbg_req_ready0, 0);
      chk("clr_init_done", init_done, 0);
      tick();
    end
    dbg_req_valid = 1'b0;
    #1 chk("init_done_rise", init_done, 1);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_stall", i), core_stall, tbl[i].e_stall);
      chk($sformatf("v%0d_ready", i), dbg_req_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d_we", i), rf_we, tbl[i].e_we);
      chk($sformatf("v%0d_src_a", i), rf_src_a, tbl[i].e_sa);
      chk($sformatf("v%0d_src_b", i), rf_src_b, tbl[i].csb);
      chk($sformatf("v%0d_in", i), rf_in, tbl[i].e_in);
      if (tbl[i].e_we) chk($sformatf("v%0d_dst", i), rf_dst, tbl[i].e_dst);
      tick();
      chk($sformatf("v%0d_rsp_valid", i), dbg_rsp_valid, tbl[i].e_rsv);
      if (tbl[i].e_rsv) chk($sformatf("v%0d_rsp_data", i), dbg_rsp_data, tbl[i].e_rsd);
    end

    // Reset in the cycle a read response is due drops it.
    drive(mk(1,0,6,1,8'h77, 1,0,2,8'h00, 0,0,0,0,0,8'h00, 0,8'h00));
    #1 chk("mr_ready", dbg_req_ready, 1);
    tick();
    reset = 1'b1;
    #1;
    chk("mr_rsp_dropped", dbg_rsp_valid, 0);
    chk("mr_ready_in_rst", dbg_req_ready, 0);
    chk("mr_init_done", init_done, 0);
    chk("mr_dst", rf_dst, 0);
    chk("mr_we", rf_we, 1);
    tick();

    // Partial walk, reset at index 4, then the full walk with a starving read.
    reset = 1'b0;
    drive(mk(0,1,5,1,8'h33, 1,0,5,8'h00, 0,0,0,0,0,8'h00, 0,8'h00));
    for (int k = 0; k < 4; k++) begin
      #1 chk("pw_dst", rf_dst, k);
      tick();
    end
    reset = 1'b1;
    #1 chk("pw_rst_dst", rf_dst, 0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rw_dst", rf_dst, k);
      chk("rw_we", rf_we, 1);
      chk("rw_in", rf_in, 8'h00);
      chk("rw_stall", core_stall, 1);
      chk("rw_ready", dbg_req_ready, 0);
      chk("rw_rsp_valid", dbg_rsp_valid, 0);
      tick();
    end
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk("sv_init_done", init_done, 1);
      chk("sv_ready", dbg_req_ready, 0);
      chk("sv_stall", core_stall, 0);
      chk("sv_we", rf_we, 1);
      chk("sv_dst", rf_dst, 5);
      chk("sv_in", rf_in, 8'h33);
      if (c == 1) begin
        chk("l0_ready", dbg_req_ready0, 1);
        chk("l0_stall", core_stall0, 1);
      end
      tick();
    end
    #1;
    chk("sv_grant_ready", dbg_req_ready, 1);
    chk("sv_grant_stall", core_stall, 1);
    chk("sv_grant_we", rf_we, 0);
    chk("sv_grant_src_a", rf_src_a, 5);
    tick();
    chk("sv_rsp_valid", dbg_rsp_valid, 1);
    chk("sv_rsp_data", dbg_rsp_data, 8'h33);
    drive(mk(0,1,6,1,8'h66, 0,0,0,8'h00, 0,0,0,0,0,8'h00, 0,8'h00));
    #1;
    chk("after_stall", core_stall, 0);
    chk("after_we", rf_we, 1);
    chk("after_dst", rf_dst, 6);
    tick();
    drive(mk(1,0,6,1,8'h77, 1,0,6,8'h00, 0,0,0,0,0,8'h00, 0,8'h00));
    #1 chk("rd6_ready", dbg_req_ready, 1);
    tick();
    chk("rd6_rsp_valid", dbg_rsp_valid, 1);
    chk("rd6_rsp_data", dbg_rsp_data, 8'h66);
    dbg_req_valid = 1'b0;
    tick();
    chk("rd6_pulse_end", dbg_rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
